// File: rtl/evg_pkg.sv
// Shared definitions for the event generator transmit path.
package evg_pkg;

  localparam int EVENTCODE_WIDTH = 8;

  typedef logic [EVENTCODE_WIDTH-1:0] eventCode_t;

  // Code 0 marks "no event": it is consumed at the source but never transmitted.
  localparam eventCode_t EVENTCODE_NULL = '0;

endpackage

// File: rtl/evg_event_fifo.sv
// Single-clock per-channel event FIFO. Pointers carry one extra wrap bit so
// full and empty are told apart; both flags are registered.
module evg_event_fifo
  import evg_pkg::*;
#(
  parameter int WIDTH = EVENTCODE_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEn,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr, rdPtr, wrPtrNext, rdPtrNext;
  logic [WIDTH-1:0] mem [DEPTH];

  assign wrPtrNext = wrPtr + (AW+1)'(wrEn);
  assign rdPtrNext = rdPtr + (AW+1)'(rdEn);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      wrPtr <= wrPtrNext;
      rdPtr <= rdPtrNext;
      empty <= (wrPtrNext == rdPtrNext);
      full  <= (wrPtrNext[AW] != rdPtrNext[AW]) &&
               (wrPtrNext[AW-1:0] == rdPtrNext[AW-1:0]);
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr[AW-1:0]] <= wrData;
  end

  assign rdData = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/evg_event_arbiter.sv
// Merges CHANNEL_COUNT buffered event sources into the single EVG event slot,
// with run-time selectable fixed-priority or round-robin arbitration.
module evg_event_arbiter #(
  parameter int                      CHANNEL_COUNT        = 4,
  parameter int                      EVENTCODE_WIDTH      = evg_pkg::EVENTCODE_WIDTH,
  parameter int                      FIFO_DEPTH           = 4,
  parameter logic [CHANNEL_COUNT-1:0] NO_BACKPRESSURE_MASK = CHANNEL_COUNT'(1),
  parameter int                      DROP_COUNT_WIDTH     = 16
) (
  input  logic                                     evgTxClk,
  input  logic                                     evgTxReset,
  input  logic [CHANNEL_COUNT*EVENTCODE_WIDTH-1:0] srcTDATA,
  input  logic [CHANNEL_COUNT-1:0]                 srcTVALID,
  output logic [CHANNEL_COUNT-1:0]                 srcTREADY,
  input  logic                                     slotAvailable,
  input  logic                                     modeRoundRobin,
  input  logic                                     statusClear,
  output logic [EVENTCODE_WIDTH-1:0]               eventTDATA,
  output logic                                     eventTVALID,
  output logic [CHANNEL_COUNT-1:0]                 overflowFlags,
  output logic [DROP_COUNT_WIDTH-1:0]              dropCount
);

  localparam int IDX_W   = $clog2(CHANNEL_COUNT);
  localparam int DROPS_W = $clog2(CHANNEL_COUNT + 1);

  logic [CHANNEL_COUNT-1:0]   fifoFull, fifoEmpty, fifoPush, fifoPop, dropNow;
  logic [EVENTCODE_WIDTH-1:0] fifoData [CHANNEL_COUNT];
  logic [IDX_W-1:0]           rrPtr, grantIdx, rrCand;
  logic [IDX_W:0]             rrSum;
  logic                       grantValid;
  logic [DROPS_W-1:0]         dropNum;
  logic [DROP_COUNT_WIDTH:0]  dropSum;

  assign srcTREADY = evgTxReset ? '0 : ~fifoFull;

  for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : gChan
    logic codeLive;
    assign codeLive = srcTVALID[i] &&
      (srcTDATA[i*EVENTCODE_WIDTH +: EVENTCODE_WIDTH] != EVENTCODE_WIDTH'(evg_pkg::EVENTCODE_NULL));

    // Sources that ignore TREADY may still land a code on a full FIFO if it is popped this cycle.
    if (NO_BACKPRESSURE_MASK[i]) begin : gNoBp
      assign fifoPush[i] = codeLive && (!fifoFull[i] || fifoPop[i]);
      assign dropNow[i]  = codeLive && fifoFull[i] && !fifoPop[i];
    end else begin : gBp
      assign fifoPush[i] = codeLive && !fifoFull[i];
      assign dropNow[i]  = 1'b0;
    end

    evg_event_fifo #(
      .WIDTH (EVENTCODE_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) uFifo (
      .clk    (evgTxClk),
      .rst    (evgTxReset),
      .wrEn   (fifoPush[i]),
      .wrData (srcTDATA[i*EVENTCODE_WIDTH +: EVENTCODE_WIDTH]),
      .rdEn   (fifoPop[i]),
      .rdData (fifoData[i]),
      .full   (fifoFull[i]),
      .empty  (fifoEmpty[i])
    );
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    rrSum      = '0;
    rrCand     = '0;
    fifoPop    = '0;
    if (slotAvailable) begin
      if (modeRoundRobin) begin
        // Scan starts just after the last RR winner and wraps modulo CHANNEL_COUNT.
        for (int k = 1; k <= CHANNEL_COUNT; k++) begin
          rrSum = {1'b0, rrPtr} + (IDX_W+1)'(k);
          if (rrSum >= (IDX_W+1)'(CHANNEL_COUNT)) rrSum = rrSum - (IDX_W+1)'(CHANNEL_COUNT);
          rrCand = rrSum[IDX_W-1:0];
          if (!grantValid && !fifoEmpty[rrCand]) begin
            grantValid = 1'b1;
            grantIdx   = rrCand;
          end
        end
      end else begin
        for (int k = CHANNEL_COUNT-1; k >= 0; k--) begin
          if (!fifoEmpty[k]) begin
            grantValid = 1'b1;
            grantIdx   = IDX_W'(k);
          end
        end
      end
    end
    if (grantValid) fifoPop[grantIdx] = 1'b1;
  end

  always_comb begin
    dropNum = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++) dropNum = dropNum + DROPS_W'(dropNow[i]);
    dropSum = (statusClear ? '0 : {1'b0, dropCount}) + (DROP_COUNT_WIDTH+1)'(dropNum);
  end

  always_ff @(posedge evgTxClk or posedge evgTxReset) begin
    if (evgTxReset) begin
      eventTVALID   <= 1'b0;
      eventTDATA    <= '0;
      overflowFlags <= '0;
      dropCount     <= '0;
      rrPtr         <= IDX_W'(CHANNEL_COUNT - 1);
    end else begin
      eventTVALID <= grantValid;
      eventTDATA  <= grantValid ? fifoData[grantIdx] : '0;
      if (grantValid && modeRoundRobin) rrPtr <= grantIdx;
      // A drop in the same cycle as a clear survives the clear.
      overflowFlags <= (statusClear ? '0 : overflowFlags) | dropNow;
      dropCount     <= dropSum[DROP_COUNT_WIDTH] ? '1 : dropSum[DROP_COUNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_evg_event_arbiter.sv
// Self-checking bench for evg_event_arbiter: table vectors, directed corner
// sequences, and a randomized run against a queue-based reference model.
module tb_evg_event_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int DCW   = 5;
  localparam int MAXC  = (1 << DCW) - 1;
  localparam logic [N-1:0] NBP = 4'b0001;

  logic           evgTxClk = 1'b0;
  logic           evgTxReset = 1'b1;
  logic [N*W-1:0] srcTDATA = '0;
  logic [N-1:0]   srcTVALID = '0;
  logic [N-1:0]   srcTREADY;
  logic           slotAvailable = 1'b0;
  logic           modeRoundRobin = 1'b0;
  logic           statusClear = 1'b0;
  logic [W-1:0]   eventTDATA;
  logic           eventTVALID;
  logic [N-1:0]   overflowFlags;
  logic [DCW-1:0] dropCount;

  evg_event_arbiter #(
    .CHANNEL_COUNT        (N),
    .EVENTCODE_WIDTH      (W),
    .FIFO_DEPTH           (DEPTH),
    .NO_BACKPRESSURE_MASK (NBP),
    .DROP_COUNT_WIDTH     (DCW)
  ) dut (
    .evgTxClk       (evgTxClk),
    .evgTxReset     (evgTxReset),
    .srcTDATA       (srcTDATA),
    .srcTVALID      (srcTVALID),
    .srcTREADY      (srcTREADY),
    .slotAvailable  (slotAvailable),
    .modeRoundRobin (modeRoundRobin),
    .statusClear    (statusClear),
    .eventTDATA     (eventTDATA),
    .eventTVALID    (eventTVALID),
    .overflowFlags  (overflowFlags),
    .dropCount      (dropCount)
  );

  always #5 evgTxClk = ~evgTxClk;

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input bit s, input bit r, input bit c);
    srcTVALID      = v;
    srcTDATA       = d;
    slotAvailable  = s;
    modeRoundRobin = r;
    statusClear    = c;
  endtask

  task automatic tick();
    @(posedge evgTxClk);
    #1;
  endtask

  task automatic reset_dut();
    evgTxReset = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset ready", srcTREADY, 0);
    @(posedge evgTxClk);
    @(posedge evgTxClk);
    #1;
    evgTxReset = 1'b0;
    check("reset valid", eventTVALID, 0);
    check("reset data", eventTDATA, 0);
    check("reset flags", overflowFlags, 0);
    check("reset count", dropCount, 0);
  endtask

  // Reference model: per-channel queues and plain counters.
  evg_pkg::eventCode_t mq[N][$];
  int                  mRr;
  int                  mCount;
  logic [N-1:0]        mFlags;
  bit                  mOutV;
  evg_pkg::eventCode_t mOutD;

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    mRr = N - 1; mCount = 0; mFlags = '0; mOutV = 0; mOutD = '0;
  endtask

  task automatic model_step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                            input bit s, input bit r, input bit c);
    int pre[N];
    int grant = -1;
    int drops = 0;
    logic [N-1:0] dflags = '0;
    logic [W-1:0] code;
    for (int i = 0; i < N; i++) pre[i] = mq[i].size();
    if (s) begin
      for (int k = 1; k <= N; k++) begin
        int idx = r ? (mRr + k) % N : k - 1;
        if (grant < 0 && pre[idx] > 0) grant = idx;
      end
    end
    mOutV = (grant >= 0);
    mOutD = '0;
    if (grant >= 0) begin
      mOutD = mq[grant].pop_front();
      if (r) mRr = grant;
    end
    for (int i = 0; i < N; i++) begin
      code = d[i*W +: W];
      if (v[i] && code != 0) begin
        if (pre[i] < DEPTH) mq[i].push_back(code);
        else if (NBP[i]) begin
          if (grant == i) mq[i].push_back(code);
          else begin drops++; dflags[i] = 1'b1; end
        end
      end
    end
    mFlags = (c ? '0 : mFlags) | dflags;
    mCount = (c ? 0 : mCount) + drops;
    if (mCount > MAXC) mCount = MAXC;
  endtask

  typedef struct {
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    bit             slot;
    logic [N-1:0]   expReady;
    bit             expValid;
    logic [W-1:0]   expData;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   expRdy;
    bit             rr;
    logic [W-1:0]   expSeq[4];

    // Latency of a single event, then fixed-priority ordering.
    vecs[0] = '{4'b0100, 32'h0021_0000, 1'b1, 4'hF, 1'b0, 8'h00};
    vecs[1] = '{4'b0000, 32'h0000_0000, 1'b1, 4'hF, 1'b1, 8'h21};
    vecs[2] = '{4'b0000, 32'h0000_0000, 1'b1, 4'hF, 1'b0, 8'h00};
    vecs[3] = '{4'b1111, 32'h3423_1201, 1'b0, 4'hF, 1'b0, 8'h00};
    vecs[4] = '{4'b0000, 32'h0000_0000, 1'b1, 4'hF, 1'b1, 8'h01};
    vecs[5] = '{4'b0000, 32'h0000_0000, 1'b1, 4'hF, 1'b1, 8'h12};
    vecs[6] = '{4'b0000, 32'h0000_0000, 1'b1, 4'hF, 1'b1, 8'h23};
    vecs[7] = '{4'b0000, 32'h0000_0000, 1'b1, 4'hF, 1'b1, 8'h34};
    vecs[8] = '{4'b0000, 32'h0000_0000, 1'b1, 4'hF, 1'b0, 8'h00};

    reset_dut();
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].valid, vecs[i].data, vecs[i].slot, 1'b0, 1'b0);
      #1;
      check($sformatf("vec%0d ready", i), srcTREADY, vecs[i].expReady);
      tick();
      check($sformatf("vec%0d valid", i), eventTVALID, vecs[i].expValid);
      check($sformatf("vec%0d data", i), eventTDATA, vecs[i].expData);
    end

    // Round-robin over four full FIFOs.
    reset_dut();
    for (int j = 0; j < DEPTH; j++) begin
      for (int i = 0; i < N; i++) d[i*W +: W] = 8'((i + 1) * 16 + j + 1);
      drive('1, d, 1'b0, 1'b1, 1'b0);
      tick();
    end
    check("rr all full ready", srcTREADY, 0);
    check("rr fill no drop", dropCount, 0);
    drive('0, '0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < N * DEPTH; k++) begin
      tick();
      check($sformatf("rr grant%0d valid", k), eventTVALID, 1);
      check($sformatf("rr grant%0d data", k), eventTDATA, ((k % N) + 1) * 16 + k / N + 1);
    end
    tick();
    check("rr drained", eventTVALID, 0);

    // Backpressure on ch1 with the slot withheld.
    reset_dut();
    for (int j = 0; j < DEPTH; j++) begin
      drive(4'b0010, 32'(8'h41 + j) << 8, 1'b0, 1'b0, 1'b0);
      #1;
      check($sformatf("bp ready%0d", j), srcTREADY[1], 1);
      tick();
    end
    drive(4'b0010, 32'h0000_4500, 1'b0, 1'b0, 1'b0);
    check("bp full ready", srcTREADY[1], 0);
    tick();
    check("bp still full", srcTREADY[1], 0);
    check("bp no drop", dropCount, 0);
    drive(4'b0010, 32'h0000_4500, 1'b1, 1'b0, 1'b0);
    tick();
    check("bp first pop data", eventTDATA, 8'h41);
    check("bp ready after pop", srcTREADY[1], 1);
    tick();
    check("bp second pop data", eventTDATA, 8'h42);
    drive('0, '0, 1'b1, 1'b0, 1'b0);
    expSeq = '{8'h43, 8'h44, 8'h45, 8'h00};
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("bp drain%0d valid", k), eventTVALID, (k < 3));
      check($sformatf("bp drain%0d data", k), eventTDATA, expSeq[k]);
    end
    check("bp drops total", dropCount, 0);

    // Drops on the no-backpressure channel, clears, and full-with-pop.
    reset_dut();
    for (int j = 0; j < DEPTH; j++) begin
      drive(4'b0001, 32'(8'h51 + j), 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("drop ch0 full", srcTREADY, 4'b1110);
    for (int j = 0; j < 3; j++) begin
      drive(4'b0001, 32'(8'h55 + j), 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("drop count 3", dropCount, 3);
    check("drop flags", overflowFlags, 4'b0001);
    drive('0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    check("clear count", dropCount, 0);
    check("clear flags", overflowFlags, 0);
    drive(4'b0001, 32'h58, 1'b0, 1'b0, 1'b1);
    tick();
    check("clear+drop count", dropCount, 1);
    check("clear+drop flags", overflowFlags, 4'b0001);
    drive(4'b0001, 32'h59, 1'b1, 1'b0, 1'b0);
    tick();
    check("full+pop data", eventTDATA, 8'h51);
    check("full+pop no drop", dropCount, 1);
    drive('0, '0, 1'b1, 1'b0, 1'b0);
    expSeq = '{8'h52, 8'h53, 8'h54, 8'h59};
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("nbp order%0d", k), eventTDATA, expSeq[k]);
    end
    tick();
    check("nbp drained", eventTVALID, 0);

    // Null code and reset in the middle of traffic.
    reset_dut();
    drive(4'b1000, '0, 1'b1, 1'b0, 1'b0);
    #1;
    check("null ready", srcTREADY[3], 1);
    tick();
    drive('0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    check("null no output a", eventTVALID, 0);
    tick();
    check("null no output b", eventTVALID, 0);
    check("null not queued", srcTREADY, 4'hF);
    drive(4'b0010, 32'h0000_6100, 1'b0, 1'b0, 1'b0);
    tick();
    drive(4'b0010, 32'h0000_6200, 1'b0, 1'b0, 1'b0);
    tick();
    drive('0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    check("pre-reset data", eventTDATA, 8'h61);
    #2;
    evgTxReset = 1'b1;
    #1;
    check("async reset valid", eventTVALID, 0);
    check("async reset data", eventTDATA, 0);
    check("async reset ready", srcTREADY, 0);
    tick();
    evgTxReset = 1'b0;
    tick();
    check("post-reset empty a", eventTVALID, 0);
    tick();
    check("post-reset empty b", eventTVALID, 0);
    check("post-reset ready", srcTREADY, 4'hF);

    // Randomized traffic against the reference model.
    reset_dut();
    model_reset();
    rr = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [N-1:0] v;
      bit s, c;
      v = N'($urandom);
      v[0] = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        d[i*W +: W] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      s = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 19) == 0) rr = ~rr;
      c = ($urandom_range(0, 199) == 0);
      drive(v, d, s, rr, c);
      #1;
      for (int i = 0; i < N; i++) expRdy[i] = (mq[i].size() < DEPTH);
      check($sformatf("rand%0d ready", cyc), srcTREADY, expRdy);
      model_step(v, d, s, rr, c);
      tick();
      check($sformatf("rand%0d valid", cyc), eventTVALID, mOutV);
      check($sformatf("rand%0d data", cyc), eventTDATA, mOutD);
      check($sformatf("rand%0d flags", cyc), overflowFlags, mFlags);
      check($sformatf("rand%0d count", cyc), dropCount, mCount);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
